// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and control-word layout for the LEGv8 sequencer.
// Field order of cw_t matches the controlWord bit positions.
package cpu_ctrl_pkg;

  localparam int CW_W = 31;
  localparam int K_W  = 64;

  localparam logic [1:0] PSEL_HOLD = 2'b00;
  localparam logic [1:0] PSEL_INC  = 2'b01;
  localparam logic [1:0] PSEL_BR   = 2'b10;

  localparam logic [4:0] FSEL_ADD      = 5'b01000;
  localparam logic [3:0] FSEL_ARITH_HI = 4'b0100;

  localparam logic [6:0]  OPC_IARITH = 7'b1000100;
  localparam logic [10:0] OPC_LDUR   = 11'h7C2;
  localparam logic [10:0] OPC_STUR   = 11'h7C0;
  localparam logic [5:0]  OPC_B      = 6'b000101;

  localparam logic [1:0] ST_0 = 2'b00;
  localparam logic [1:0] ST_1 = 2'b01;

  localparam logic [4:0] REG_ZR = 5'd31;

  // Psel[30:29] DA[28:24] SA[23:19] SB[18:14] Fsel[13:9]
  // then the single-bit strobes/selects down to SL[0].
  typedef struct packed {
    logic [1:0] psel;
    logic [4:0] da;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] fsel;
    logic       regw;
    logic       ramw;
    logic       en_mem;
    logic       en_alu;
    logic       en_b;
    logic       en_pc;
    logic       bsel;
    logic       pcsel;
    logic       sl;
  } cw_t;

  localparam cw_t CW_NOP = '0;

endpackage

// File: rtl/cw_decode.sv
// Combinational decode of (IR, state) into control word and constant.
// Opcode classes are mutually exclusive; anything else is illegal.
module cw_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0]    i_ir,
  input  logic [1:0]     i_state,
  output cw_t            o_cw,
  output logic [K_W-1:0] o_k,
  output logic [1:0]     o_next_state,
  output logic           o_illegal
);

  logic w_iarith;
  logic w_ldur;
  logic w_stur;
  logic w_b;
  logic [K_W-1:0] w_k_dt;

  assign w_iarith = (i_ir[28:22] == OPC_IARITH);
  assign w_ldur   = (i_ir[31:21] == OPC_LDUR);
  assign w_stur   = (i_ir[31:21] == OPC_STUR);
  assign w_b      = (i_ir[31:26] == OPC_B);
  assign w_k_dt   = {{55{i_ir[20]}}, i_ir[20:12]};

  // Per-class field assembly; LDUR is the only two-state class.
  always_comb begin
    o_cw         = CW_NOP;
    o_k          = '0;
    o_next_state = ST_0;
    o_illegal    = 1'b0;
    unique case (1'b1)
      w_iarith: begin
        o_cw.psel   = PSEL_INC;
        o_cw.da     = i_ir[4:0];
        o_cw.sa     = i_ir[9:5];
        o_cw.sb     = REG_ZR;
        o_cw.fsel   = {FSEL_ARITH_HI, i_ir[30]};
        o_cw.regw   = 1'b1;
        o_cw.en_alu = 1'b1;
        o_cw.bsel   = 1'b1;
        o_cw.sl     = i_ir[29];
        o_k         = {52'd0, i_ir[21:10]};
      end
      w_ldur: begin
        o_cw.sa   = i_ir[9:5];
        o_cw.fsel = FSEL_ADD;
        o_cw.bsel = 1'b1;
        o_k       = w_k_dt;
        if (i_state == ST_0) begin
          o_next_state = ST_1;
        end else begin
          o_cw.psel   = PSEL_INC;
          o_cw.da     = i_ir[4:0];
          o_cw.regw   = 1'b1;
          o_cw.en_mem = 1'b1;
        end
      end
      w_stur: begin
        o_cw.psel = PSEL_INC;
        o_cw.sa   = i_ir[9:5];
        o_cw.sb   = i_ir[4:0];
        o_cw.fsel = FSEL_ADD;
        o_cw.bsel = 1'b1;
        o_cw.ramw = 1'b1;
        o_k       = w_k_dt;
      end
      w_b: begin
        o_cw.psel = PSEL_BR;
        o_k       = {{38{i_ir[25]}}, i_ir[25:0]};
      end
      default: begin
        o_cw.psel = PSEL_INC;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle LEGv8 sequencer: IR/state/busy registers,
// memory-stall gating and the fetch valid/ready handshake.
module cpu_control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     instr_in,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic            mem_ready,
  output logic [CW_W-1:0] controlWord,
  output logic [K_W-1:0]  K,
  output logic [1:0]      state,
  output logic            busy,
  output logic            illegal
);

  logic [31:0] r_ir;
  logic [1:0]  r_state;
  logic        r_busy;

  cw_t            w_cw_dec;
  cw_t            w_cw;
  logic [K_W-1:0] w_k;
  logic [1:0]     w_next;
  logic           w_illegal;
  logic           w_active;
  logic           w_stall;
  logic           w_retire;
  logic           w_issue;

  cw_decode u_dec (
    .i_ir         (r_ir),
    .i_state      (r_state),
    .o_cw         (w_cw_dec),
    .o_k          (w_k),
    .o_next_state (w_next),
    .o_illegal    (w_illegal)
  );

  // Reset masks the decoder so no strobe leaks in the reset cycle.
  assign w_active = r_busy & ~reset;
  assign w_stall  = w_active & ~mem_ready
                  & (w_cw_dec.en_mem | w_cw_dec.ramw);
  assign w_retire = w_active & ~w_stall & (w_next == ST_0);

  assign instr_ready = ~reset & (~r_busy | w_retire);
  assign w_issue     = instr_ready & instr_valid;

  // Idle emits NOP; a stall suppresses PC and write strobes.
  always_comb begin
    w_cw = CW_NOP;
    if (w_active) begin
      w_cw = w_cw_dec;
      if (w_stall) begin
        w_cw.psel = PSEL_HOLD;
        w_cw.regw = 1'b0;
        w_cw.ramw = 1'b0;
      end
    end
  end

  assign controlWord = w_cw;
  assign K           = w_active ? w_k : '0;
  assign illegal     = w_active & w_illegal;
  assign state       = r_state;
  assign busy        = r_busy;

  // Issue has priority over retire for zero-bubble back-to-back.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ir    <= '0;
      r_state <= ST_0;
      r_busy  <= 1'b0;
    end else if (w_issue) begin
      r_ir    <= instr_in;
      r_state <= ST_0;
      r_busy  <= 1'b1;
    end else if (w_active & ~w_stall) begin
      r_state <= w_next;
      if (w_next == ST_0) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed plus random bench for cpu_control_sequencer against
// an instruction-level reference model of the sequencing rules.
module tb_cpu_control_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins;
  logic        valid;
  logic        rdy;
  logic        mr;
  logic [30:0] cw;
  logic [63:0] k;
  logic [1:0]  st;
  logic        bsy;
  logic        ill;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: instruction in flight and its step index.
  logic [31:0] m_ir;
  bit          m_busy;
  bit          m_step;
  bit          e_stall;
  bit          e_last;
  bit          e_rdy;

  localparam logic [31:0] ADDI = 32'h91001441;
  localparam logic [31:0] LDUR = 32'hF8408083;
  localparam logic [31:0] STUR = 32'hF81FD0C5;

  cpu_control_sequencer dut (
    .clock       (clk),
    .reset       (rst),
    .instr_in    (ins),
    .instr_valid (valid),
    .instr_ready (rdy),
    .mem_ready   (mr),
    .controlWord (cw),
    .K           (k),
    .state       (st),
    .busy        (bsy),
    .illegal     (ill)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit v,
                       input logic [31:0] i, input bit m);
    rst   = r;
    valid = v;
    ins   = i;
    mr    = m;
  endtask

  // Expected outputs from the instruction class and step.
  task automatic sample();
    logic [1:0]  psel;
    logic [4:0]  da, sa, sb, fsel;
    logic        regw, ramw, enmem, enalu, bsel, sl;
    logic        eill, act;
    logic [63:0] ek;
    logic [30:0] ecw;
    @(negedge clk);
    {psel, da, sa, sb, fsel} = '0;
    {regw, ramw, enmem, enalu, bsel, sl} = '0;
    eill   = 1'b0;
    ek     = '0;
    e_last = 1'b1;
    if (m_ir[28:22] == 7'b1000100) begin
      psel  = 2'd1;
      da    = m_ir[4:0];
      sa    = m_ir[9:5];
      sb    = 5'd31;
      fsel  = {4'b0100, m_ir[30]};
      regw  = 1'b1;
      enalu = 1'b1;
      bsel  = 1'b1;
      sl    = m_ir[29];
      ek    = 64'(m_ir[21:10]);
    end else if (m_ir[31:21] == 11'h7C2) begin
      sa   = m_ir[9:5];
      fsel = 5'd8;
      bsel = 1'b1;
      ek   = 64'($signed(m_ir[20:12]));
      if (!m_step) begin
        e_last = 1'b0;
      end else begin
        psel  = 2'd1;
        da    = m_ir[4:0];
        regw  = 1'b1;
        enmem = 1'b1;
      end
    end else if (m_ir[31:21] == 11'h7C0) begin
      psel = 2'd1;
      sa   = m_ir[9:5];
      sb   = m_ir[4:0];
      fsel = 5'd8;
      bsel = 1'b1;
      ramw = 1'b1;
      ek   = 64'($signed(m_ir[20:12]));
    end else if (m_ir[31:26] == 6'b000101) begin
      psel = 2'd2;
      ek   = 64'($signed(m_ir[25:0]));
    end else begin
      psel = 2'd1;
      eill = 1'b1;
    end
    act     = m_busy && !rst;
    e_stall = act && (enmem || ramw) && !mr;
    if (e_stall) begin
      psel = 2'd0;
      regw = 1'b0;
      ramw = 1'b0;
    end
    ecw = {psel, da, sa, sb, fsel, regw, ramw, enmem,
           enalu, 1'b0, 1'b0, bsel, 1'b0, sl};
    if (!act) begin
      ecw  = '0;
      ek   = '0;
      eill = 1'b0;
    end
    e_rdy = !rst && (!m_busy || (act && !e_stall && e_last));
    check("controlWord", 64'(cw), 64'(ecw));
    check("K", k, ek);
    check("state", 64'(st), 64'(m_step));
    check("busy", 64'(bsy), 64'(m_busy));
    check("illegal", 64'(ill), 64'(eill));
    check("instr_ready", 64'(rdy), 64'(e_rdy));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0;
      m_ir   = '0;
      m_step = 1'b0;
    end else if (e_rdy && valid) begin
      m_ir   = ins;
      m_busy = 1'b1;
      m_step = 1'b0;
    end else if (m_busy && !e_stall) begin
      m_busy = !e_last;
      m_step = !e_last;
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 4))
      0: w[28:22] = 7'b1000100;
      1: w[31:21] = 11'h7C2;
      2: w[31:21] = 11'h7C0;
      3: w[31:26] = 6'b000101;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    bit took;
    m_ir   = '0;
    m_busy = 1'b0;
    m_step = 1'b0;
    e_rdy  = 1'b0;
    // Reset held two cycles with a valid instruction offered.
    drive(1, 1, ADDI, 1);
    tick();
    sample();
    tick();
    drive(0, 0, ADDI, 1);
    sample();
    check("idle_cw", 64'(cw), 64'd0);
    check("idle_ready", 64'(rdy), 64'd1);
    tick();
    // ADDI X1,X2,#5
    drive(0, 1, ADDI, 1);
    sample();
    tick();
    drive(0, 0, ADDI, 1);
    sample();
    check("addi_cw", 64'(cw), 64'h2117D124);
    check("addi_k", k, 64'd5);
    tick();
    sample();
    check("addi_done", 64'(bsy), 64'd0);
    tick();
    // LDUR X3,[X4,#8] with two stall cycles
    drive(0, 1, LDUR, 0);
    sample();
    tick();
    drive(0, 0, LDUR, 0);
    for (int i = 0; i < 3; i++) begin
      sample();
      tick();
    end
    drive(0, 0, LDUR, 1);
    sample();
    check("ldur_cw", 64'(cw), 64'h23201144);
    check("ldur_k", k, 64'd8);
    tick();
    sample();
    tick();
    // Back-to-back ADDI then STUR
    drive(0, 1, ADDI, 1);
    sample();
    tick();
    drive(0, 1, STUR, 1);
    sample();
    check("b2b_ready1", 64'(rdy), 64'd1);
    tick();
    drive(0, 0, STUR, 1);
    sample();
    check("b2b_ready2", 64'(rdy), 64'd1);
    check("stur_ramw", 64'(cw[7]), 64'd1);
    check("stur_sb", 64'(cw[18:14]), 64'd5);
    tick();
    sample();
    tick();
    // Illegal all-zero word
    drive(0, 1, 32'h0, 1);
    sample();
    tick();
    drive(0, 0, 32'h0, 1);
    sample();
    check("ill_pulse", 64'(ill), 64'd1);
    check("ill_cw", 64'(cw), 64'h20000000);
    tick();
    sample();
    check("ill_clear", 64'(ill), 64'd0);
    tick();
    // Reset while LDUR sits in its second state
    drive(0, 1, LDUR, 1);
    sample();
    tick();
    drive(0, 0, LDUR, 1);
    sample();
    tick();
    drive(1, 0, LDUR, 1);
    sample();
    check("rst_regw", 64'(cw[8]), 64'd0);
    tick();
    drive(0, 0, LDUR, 1);
    sample();
    check("rst_busy", 64'(bsy), 64'd0);
    check("rst_cw", 64'(cw), 64'd0);
    tick();
    // Random traffic; fetch holds a word until it is taken.
    took  = 1'b1;
    valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!valid || took) begin
        valid = ($urandom_range(0, 3) != 0);
        ins   = rand_instr();
      end
      rst = ($urandom_range(0, 99) == 0);
      mr  = ($urandom_range(0, 3) != 0);
      sample();
      took = e_rdy && valid;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_control_sequencer.md
# cpu_control_sequencer

Multi-cycle instruction sequencer for the LEGv8 datapath. It accepts instructions from fetch and latches each one in an instruction register. It steps a 2-bit execution state, emitting the 31-bit control word and 64-bit constant K for the current (instruction, state) pair, and stalls on memory. It replaces the free-running state loopback around the per-class decoders with one registered controller that owns sequencing, back-to-back issue and illegal-opcode handling.

## Interface
- No parameters; all field positions and opcodes are fixed constants in the shared package.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_in  in  32  instruction word from fetch.
- instr_valid  in  1  instr_in is valid this cycle.
- instr_ready  out  1  sequencer takes instr_in on this edge if instr_valid.
- mem_ready  in  1  data memory completes the access this cycle.
- controlWord  out  31  {Psel[30:29], DA[28:24], SA[23:19], SB[18:14], Fsel[13:9], regW[8], ramW[7], EN_MEM[6], EN_ALU[5], EN_B[4], EN_PC[3], Bsel[2], PCsel[1], SL[0]}.
- K  out  64  constant routed to the ALU B input when Bsel=1.
- state  out  2  current execution state (00 when idle).
- busy  out  1  an instruction is in flight.
- illegal  out  1  one-cycle pulse when an unrecognised instruction retires.

## Operation
- Registers: IR[31:0], state[1:0], busy. All three reset to 0.
- Idle (busy=0): controlWord=0 and K=0, so no register, RAM or PC write occurs. instr_ready=1.
- Issue: when instr_ready and instr_valid, the block loads IR, sets busy=1 and sets state=00.
- Outputs while busy are combinational from (IR, state). Psel encodings are 00 hold, 01 PC+4, 10 PC+4·K.
- **I-arith** (IR[28:22]=1000100): one state.
  - Psel=01, DA=IR[4:0], SA=IR[9:5], SB=31.
  - Fsel={0100,IR[30]}, regW=1, EN_ALU=1, Bsel=1, SL=IR[29].
  - K=zero-extended IR[21:10]. nextState=00.
- **LDUR** (IR[31:21]=0x7C2): two states.
  - Both states: SA=IR[9:5], Fsel=01000, Bsel=1, K=sign-extended IR[20:12].
  - State 00: Psel=00, regW=0, EN_MEM=0, nextState=01.
  - State 01: DA=IR[4:0], EN_MEM=1, regW=1, Psel=01, nextState=00.
- **STUR** (IR[31:21]=0x7C0): one state.
  - SA=IR[9:5], SB=IR[4:0], Fsel=01000, Bsel=1.
  - ramW=1, Psel=01, K as for LDUR. nextState=00.
- **B** (IR[31:26]=000101): Psel=10, K=sign-extended IR[25:0], all other fields 0. nextState=00.
- **Any other encoding**: Psel=01, all other fields 0, K=0, nextState=00. illegal=1 during that cycle.
- Memory stall: a cycle with EN_MEM=1 or ramW=1 and mem_ready=0 is a stall cycle. During a stall:
  - IR, state and busy hold.
  - Psel and regW are forced to 0; ramW is forced to 0 except on the completing cycle.
- Advance on a non-stall cycle:
  - state <= nextState.
  - If nextState=00 the instruction retires: busy <= 0, unless a new instruction issues in the same cycle.
- instr_ready = !busy OR (retiring this cycle). This gives zero-bubble back-to-back issue.

## Timing
- Issue to first control word: one cycle; controlWord reflects the new IR in the cycle after the accepting edge.
- Latency with no stalls:
  - I-arith, STUR, B, illegal: 1 busy cycle each.
  - LDUR: 2 busy cycles.
- Each cycle of mem_ready=0 adds exactly one cycle to LDUR state 01 or to STUR.
- Reset mid-instruction: on the next edge IR=0, state=00 and busy=0. No write strobe is asserted in the reset cycle.
- instr_valid while instr_ready=0 is ignored; fetch holds the word.
- illegal and the retire indication coincide in the same cycle.

## Structure
- Package cpu_ctrl_pkg holds:
  - controlWord field offsets and widths.
  - Psel and Fsel encodings.
  - Opcode match constants (I-arith, 0x7C2, 0x7C0, B).
  - The NOP control word.
- Sub-module cw_decode: purely combinational; (IR, state) → controlWord, K, nextState, illegal.
- cpu_control_sequencer holds only the IR, state and busy registers, the stall gating and the handshake.

## Test plan
- **Reset:** hold reset 2 cycles with instr_valid=1 → busy=0, controlWord=0, K=0, state=00, instr_ready=1.
- **ADDI X1,X2,#5** (0x91001441): one busy cycle with
  - Psel=01, DA=1, SA=2, SB=31, Fsel=01000.
  - regW=1, EN_ALU=1, Bsel=1, SL=0, K=5.
  - busy drops next cycle.
- **LDUR X3,[X4,#8]** (0xF8408083) with mem_ready low 2 cycles → sequence is:
  - state 00 once (Psel=00, regW=0).
  - state 01 for 3 cycles, with regW/Psel at 0 until mem_ready=1.
  - final cycle: regW=1, Psel=01, DA=3, K=8.
- **Back-to-back:** ADDI then STUR with instr_valid held high → no idle cycle between them. Second control word has ramW=1, SB=Rt, and instr_ready=1 on both retire cycles.
- **Illegal:** 0x00000000 → illegal=1 for exactly one cycle, Psel=01, regW=ramW=EN_MEM=0.
- **Reset during LDUR state 01** → next cycle busy=0, state=00, controlWord=0, and no regW pulse.
